// File: rtl/snake_dir_ctrl.sv
// Debounces four active-low KEYs into arbitrated direction requests and commits a heading on each move tick.
// Latency: press to key_event is DEBOUNCE_CYCLES+3 edges; direction updates on the edge that samples move_tick.
module snake_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       VGA_CLK,
    input  logic       reset,
    input  logic       sw0,
    input  logic       sw1,
    input  logic       sw2,
    input  logic       sw3,
    input  logic       move_tick,
    output logic [2:0] direction,
    output logic       key_event
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       raw_keys;
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [3:0]       stable_q, stable_d;
    logic [3:0]       stable_dly_q, stable_dly_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [2:0]       pending_q, pending_d;
    logic [2:0]       committed_q, committed_d;
    logic             key_event_q, key_event_d;

    logic [3:0]       press;
    logic [2:0]       req;
    logic             req_vld;
    logic [2:0]       ref_dir;
    logic             opposite;

    assign raw_keys = {sw3, sw2, sw1, sw0};

    always_comb begin
        sync1_d      = raw_keys;
        sync2_d      = sync1_q;
        stable_d     = stable_q;
        stable_dly_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else if (cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Press is the registered 1->0 edge of the debounced level; releases are ignored.
    assign press = stable_dly_q & ~stable_q;

    always_comb begin
        req_vld = 1'b1;
        req     = 3'd0;
        if (press[0])      req = 3'd1;
        else if (press[1]) req = 3'd2;
        else if (press[2]) req = 3'd3;
        else if (press[3]) req = 3'd4;
        else               req_vld = 1'b0;
    end

    // On a tick the outgoing pending value becomes the heading, so check against it.
    assign ref_dir  = move_tick ? pending_q : committed_q;
    assign opposite = (req == 3'd1 && ref_dir == 3'd2) || (req == 3'd2 && ref_dir == 3'd1) ||
                      (req == 3'd3 && ref_dir == 3'd4) || (req == 3'd4 && ref_dir == 3'd3);

    always_comb begin
        pending_d   = pending_q;
        key_event_d = 1'b0;
        committed_d = move_tick ? pending_q : committed_q;
        if (req_vld && !opposite) begin
            pending_d   = req;
            key_event_d = 1'b1;
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            sync1_q      <= 4'hf;
            sync2_q      <= 4'hf;
            stable_q     <= 4'hf;
            stable_dly_q <= 4'hf;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            pending_q    <= 3'd0;
            committed_q  <= 3'd0;
            key_event_q  <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            pending_q    <= pending_d;
            committed_q  <= committed_d;
            key_event_q  <= key_event_d;
        end
    end

    assign direction = committed_q;
    assign key_event = key_event_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl with a short debounce window.
module tb_snake_dir_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw_n;
    logic       move_tick;
    logic [2:0] direction;
    logic       key_event;

    int checks = 0;
    int passed = 0;
    int ev_cnt = 0;

    snake_dir_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .VGA_CLK  (clk),
        .reset    (reset),
        .sw0      (sw_n[0]),
        .sw1      (sw_n[1]),
        .sw2      (sw_n[2]),
        .sw3      (sw_n[3]),
        .move_tick(move_tick),
        .direction(direction),
        .key_event(key_event)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (key_event === 1'b1) ev_cnt = ev_cnt + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else passed++;
    endtask

    // Hold the masked keys low long enough to debounce, then release and let it settle.
    task automatic press(input logic [3:0] mask);
        sw_n = ~mask;
        repeat (10) @(negedge clk);
        sw_n = 4'hf;
        repeat (10) @(negedge clk);
    endtask

    task automatic tick();
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sw_n = 4'hf;
        move_tick = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (direction !== 3'd0) $display("FAIL reset_dir: got %0d expected 0", direction);
        else passed++;
        checks++;
        if (key_event !== 1'b0) $display("FAIL reset_kev: got %0d expected 0", key_event);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (direction !== 3'd0) $display("FAIL post_reset_dir: got %0d expected 0", direction);
        else passed++;
    endtask

    task automatic test_first_press();
        int e0;
        e0 = ev_cnt;
        sw_n[3] = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++;
            if (key_event !== (i == 7)) $display("FAIL kev_timing cyc%0d: got %0d expected %0d", i, key_event, (i == 7));
            else passed++;
        end
        checks++;
        if (ev_cnt - e0 !== 1) $display("FAIL held_single_event: got %0d expected 1", ev_cnt - e0);
        else passed++;
        sw_n[3] = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (direction !== 3'd0) $display("FAIL dir_before_tick: got %0d expected 0", direction);
        else passed++;
        tick();
        checks++;
        if (direction !== 3'd4) $display("FAIL dir_after_tick: got %0d expected 4", direction);
        else passed++;
    endtask

    task automatic test_bounce();
        int e0;
        e0 = ev_cnt;
        for (int r = 0; r < 5; r++) begin
            sw_n[0] = 1'b0;
            repeat (3) @(negedge clk);
            sw_n[0] = 1'b1;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (ev_cnt - e0 !== 0) $display("FAIL bounce_events: got %0d expected 0", ev_cnt - e0);
        else passed++;
        tick();
        checks++;
        if (direction !== 3'd4) $display("FAIL bounce_dir: got %0d expected 4", direction);
        else passed++;
    endtask

    task automatic test_reversal();
        int e0;
        press(4'b0001);
        tick();
        checks++;
        if (direction !== 3'd1) $display("FAIL rev_setup_dir: got %0d expected 1", direction);
        else passed++;
        e0 = ev_cnt;
        press(4'b0010);
        tick();
        checks++;
        if (ev_cnt - e0 !== 0) $display("FAIL rev_events: got %0d expected 0", ev_cnt - e0);
        else passed++;
        checks++;
        if (direction !== 3'd1) $display("FAIL rev_dir: got %0d expected 1", direction);
        else passed++;
        press(4'b0100);
        tick();
        checks++;
        if (direction !== 3'd3) $display("FAIL rev_down_dir: got %0d expected 3", direction);
        else passed++;
    endtask

    task automatic test_double_press();
        int e0;
        press(4'b0001);
        tick();
        e0 = ev_cnt;
        press(4'b1000);
        press(4'b0010);
        checks++;
        if (ev_cnt - e0 !== 1) $display("FAIL dbl_events: got %0d expected 1", ev_cnt - e0);
        else passed++;
        checks++;
        if (direction !== 3'd1) $display("FAIL dbl_pre_tick_dir: got %0d expected 1", direction);
        else passed++;
        tick();
        checks++;
        if (direction !== 3'd4) $display("FAIL dbl_dir: got %0d expected 4", direction);
        else passed++;
    endtask

    task automatic test_priority();
        int e0;
        press(4'b0001);
        tick();
        e0 = ev_cnt;
        press(4'b1100);
        checks++;
        if (ev_cnt - e0 !== 1) $display("FAIL prio_events: got %0d expected 1", ev_cnt - e0);
        else passed++;
        tick();
        checks++;
        if (direction !== 3'd3) $display("FAIL prio_dir: got %0d expected 3", direction);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int e0;
        press(4'b0001);
        tick();
        press(4'b0100);
        e0 = ev_cnt;
        sw_n[3] = 1'b0;
        repeat (6) @(negedge clk);
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        checks++;
        if (direction !== 3'd3) $display("FAIL coinc_dir: got %0d expected 3", direction);
        else passed++;
        checks++;
        if (key_event !== 1'b0) $display("FAIL coinc_kev: got %0d expected 0", key_event);
        else passed++;
        repeat (3) @(negedge clk);
        sw_n[3] = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (ev_cnt - e0 !== 0) $display("FAIL coinc_events: got %0d expected 0", ev_cnt - e0);
        else passed++;
        tick();
        checks++;
        if (direction !== 3'd3) $display("FAIL coinc_next_dir: got %0d expected 3", direction);
        else passed++;
    endtask

    task automatic test_mid_reset();
        int e0;
        e0 = ev_cnt;
        sw_n[0] = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        move_tick = 1'b1;
        sw_n[0] = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        move_tick = 1'b0;
        checks++;
        if (direction !== 3'd0) $display("FAIL mid_reset_dir: got %0d expected 0", direction);
        else passed++;
        repeat (15) @(negedge clk);
        checks++;
        if (ev_cnt - e0 !== 0) $display("FAIL mid_reset_events: got %0d expected 0", ev_cnt - e0);
        else passed++;
        tick();
        checks++;
        if (direction !== 3'd0) $display("FAIL mid_reset_tick_dir: got %0d expected 0", direction);
        else passed++;
        chk("mid_reset_kev", int'(key_event), 0);
    endtask

    initial begin
        test_reset();
        test_first_press();
        test_bounce();
        test_reversal();
        test_double_press();
        test_priority();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
